// File: rtl/phy_sym_pkg.sv
// phy_sym_pkg: PHY symbol constants, mux select encodings and scheduler states
package phy_sym_pkg;
    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;
    localparam logic [7:0] FTS = 8'h3C;
    localparam logic [7:0] COM = 8'hBC;
    typedef enum logic [1:0] {SEL_DATA = 2'b00, SEL_SE = 2'b01, SEL_OS = 2'b10, SEL_COM = 2'b11} sel_e;
    typedef enum logic [2:0] {S_COM, S_OS, S_STP, S_DATA, S_END, S_EDB} state_e;
endpackage

// File: rtl/phy_tx_scheduler_if.sv
// phy_tx_scheduler_if: packet source handshake plus symbol mux outputs
interface phy_tx_scheduler_if;
    logic pkt_valid, pkt_last, pkt_abort, pkt_ready, skp_sent, underrun;
    logic [7:0] pkt_data, d, start_end, ordered_set, log_com;
    logic [1:0] control;
    modport master (
        output pkt_valid, pkt_data, pkt_last, pkt_abort,
        input  pkt_ready, d, start_end, ordered_set, log_com, control, skp_sent, underrun
    );
    modport slave (
        input  pkt_valid, pkt_data, pkt_last, pkt_abort,
        output pkt_ready, d, start_end, ordered_set, log_com, control, skp_sent, underrun
    );
endinterface

// File: rtl/skp_timer.sv
// skp_timer: free-running interval counter raising a single pending SKP request
module skp_timer #(
    parameter int INTERVAL = 16,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic pending
);
    logic [CNT_W-1:0] cnt;
    logic wrap;
    assign wrap = cnt == CNT_W'(INTERVAL - 1);
    // a wrap while already pending is absorbed; a wrap on the clearing edge re-arms
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            pending <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
            pending <= wrap | (pending & ~clr);
        end
    end
endmodule

// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler: frames packets, fills idle with IDL sets and inserts periodic SKP sets
module phy_tx_scheduler
    import phy_sym_pkg::*;
#(
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_LEN = 3,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    phy_tx_scheduler_if.slave bus
);
    state_e state, state_nx;
    logic kind_skp, kind_nx, und_q, pending, clr, os_last, boundary, accept;
    logic [2:0] os_cnt;
    logic [1:0] control_nx;
    logic [7:0] d_nx, se_nx, os_nx;
    logic skp_sent_nx, underrun_nx;

    skp_timer #(.INTERVAL(SKP_INTERVAL), .CNT_W(CNT_W)) u_skp (.clk, .rst, .clr, .pending);

    assign os_last = os_cnt == (kind_skp ? 3'(SKP_LEN - 1) : 3'd2);
    assign boundary = (state == S_OS && os_last) || state == S_END || state == S_EDB;
    assign accept = state == S_DATA && bus.pkt_valid && !bus.pkt_abort;
    assign clr = boundary && pending;
    assign bus.pkt_ready = state == S_DATA;
    assign bus.log_com = COM;

    // state and symbol registers; each edge loads the symbol of the state being left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_COM;
            kind_skp <= 1'b0;
            os_cnt <= '0;
            und_q <= 1'b0;
            bus.control <= SEL_COM;
            bus.d <= '0;
            bus.start_end <= END;
            bus.ordered_set <= IDL;
            bus.skp_sent <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            state <= state_nx;
            kind_skp <= kind_nx;
            os_cnt <= state == S_OS ? os_cnt + 3'd1 : '0;
            und_q <= state == S_DATA && !bus.pkt_valid && !bus.pkt_abort;
            bus.control <= control_nx;
            bus.d <= d_nx;
            bus.start_end <= se_nx;
            bus.ordered_set <= os_nx;
            bus.skp_sent <= skp_sent_nx;
            bus.underrun <= underrun_nx;
        end
    end

    // next state: SKP beats a waiting packet at a boundary, packets are never interrupted
    always_comb begin
        kind_nx = boundary ? pending : kind_skp;
        state_nx = boundary ? (pending || !bus.pkt_valid ? S_COM : S_STP)
                 : state == S_COM ? S_OS
                 : state == S_STP ? S_DATA
                 : state == S_DATA ? (!accept ? S_EDB : bus.pkt_last ? S_END : S_DATA)
                 : state;
    end

    // symbol selection; a missing or aborted byte holds the previous symbol, which EDB nullifies
    always_comb begin
        control_nx = bus.control;
        d_nx = bus.d;
        se_nx = bus.start_end;
        os_nx = bus.ordered_set;
        skp_sent_nx = 1'b0;
        underrun_nx = 1'b0;
        case (state)
            S_COM: begin
                control_nx = SEL_COM;
                os_nx = kind_skp ? SKP : IDL;
                skp_sent_nx = kind_skp;
            end
            S_OS: control_nx = SEL_OS;
            S_STP: begin
                control_nx = SEL_SE;
                se_nx = STP;
            end
            S_DATA: if (accept) begin
                control_nx = SEL_DATA;
                d_nx = bus.pkt_data;
            end
            S_END: begin
                control_nx = SEL_SE;
                se_nx = END;
            end
            S_EDB: begin
                control_nx = SEL_SE;
                se_nx = EDB;
                underrun_nx = und_q;
            end
            default: ;
        endcase
    end
endmodule
